// File: rtl/key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : key_ctrl
//  Description : Push-button front end for the 2048 game controller.
//                Each raw button is synchronized (2 flops), debounced, and
//                rising-edge detected. One press is held in a single-entry
//                pending register. It is released as a one-cycle move pulse
//                only when the controller reports INPUT. The controller state
//                is then tracked so that one press yields exactly one move.
//
//  Ports       : clk                     system clock
//                rst                     asynchronous active-high reset
//                btn_up/down/left/right  raw move buttons (async, active-high)
//                btn_switch              raw AI-mode button
//                state[2:0]              controller state (INPUT=000, END=100)
//                up/down/left/right      one-cycle move pulses
//                switch                  one-cycle AI-search request pulse
//                busy                    request pending or in flight
//                dropped                 one-cycle pulse on a discarded press
//
//  Revision    : 1.0  initial release
// ============================================================================
module key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_switch,
    input  logic [2:0] state,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       switch,
    output logic       busy,
    output logic       dropped
);

    localparam logic [2:0] c_ST_IDLE        = 3'd0;
    localparam logic [2:0] c_ST_FIRE        = 3'd1;
    localparam logic [2:0] c_ST_WAIT_LEAVE  = 3'd2;
    localparam logic [2:0] c_ST_WAIT_RETURN = 3'd3;
    localparam logic [2:0] c_ST_LOCKED      = 3'd4;

    localparam logic [2:0] c_CTRL_INPUT = 3'b000;
    localparam logic [2:0] c_CTRL_END   = 3'b100;

    // Counter value on the DEBOUNCE_CYCLES-th consecutive differing sample.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 is the highest priority (UP), bit 4 the lowest (SWITCH).
    logic [4:0] w_btn_raw;
    logic [4:0] w_level;
    logic [4:0] r_level_q;
    logic [4:0] w_rise;
    logic [4:0] w_sel;
    logic [4:0] w_latch;
    logic       w_accept;
    logic [4:0] r_pend;      // one-hot pending request, 0 = empty
    logic [2:0] r_fsm;
    logic [2:0] w_fsm_next;
    logic [1:0] r_wait_cnt;
    logic       w_in_input;
    logic       w_fire;

    assign w_btn_raw = {btn_switch, btn_right, btn_left, btn_down, btn_up};

    // ------------------------------------------------------------------
    // Per-button synchronizer and debouncer
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_btn
            logic             r_sync1;
            logic             r_sync2;
            logic             r_lvl;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_lvl   <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_btn_raw[gi];
                    r_sync2 <= r_sync1;
                    if (r_sync2 != r_lvl) begin
                        if (r_cnt == c_CNT_LAST) begin
                            r_lvl <= r_sync2;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        // Any agreeing sample restarts the stability count.
                        r_cnt <= '0;
                    end
                end
            end

            assign w_level[gi] = r_lvl;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Edge detect, priority select and pending register
    // ------------------------------------------------------------------
    assign w_rise   = w_level & ~r_level_q;
    assign w_sel    = w_rise & (~w_rise + 5'd1);   // isolate lowest set bit
    assign w_accept = (r_pend == 5'd0) && (r_fsm == c_ST_IDLE);
    assign w_latch  = w_accept ? w_sel : 5'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_q <= 5'd0;
            r_pend    <= 5'd0;
        end else begin
            r_level_q <= w_level;
            if (r_fsm == c_ST_FIRE) begin
                r_pend <= 5'd0;
            end else if (w_latch != 5'd0) begin
                r_pend <= w_latch;
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    assign w_in_input = (state == c_CTRL_INPUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm      <= c_ST_IDLE;
            r_wait_cnt <= 2'd0;
        end else begin
            r_fsm <= w_fsm_next;
            // Counts INPUT cycles spent in WAIT_LEAVE to detect a rejected move.
            if ((r_fsm == c_ST_WAIT_LEAVE) && (w_fsm_next == c_ST_WAIT_LEAVE)) begin
                r_wait_cnt <= r_wait_cnt + 2'd1;
            end else begin
                r_wait_cnt <= 2'd0;
            end
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            c_ST_IDLE: begin
                if ((r_pend != 5'd0) && w_in_input) begin
                    w_fsm_next = c_ST_FIRE;
                end
            end
            c_ST_FIRE: begin
                w_fsm_next = c_ST_WAIT_LEAVE;
            end
            c_ST_WAIT_LEAVE: begin
                if (!w_in_input) begin
                    w_fsm_next = c_ST_WAIT_RETURN;
                end else if (r_wait_cnt == 2'd3) begin
                    w_fsm_next = c_ST_IDLE;
                end
            end
            c_ST_WAIT_RETURN: begin
                if (w_in_input) begin
                    w_fsm_next = c_ST_IDLE;
                end
            end
            c_ST_LOCKED: begin
                w_fsm_next = c_ST_LOCKED;
            end
            default: begin
                w_fsm_next = c_ST_IDLE;
            end
        endcase
        // Game over overrides everything; only rst leaves LOCKED.
        if (state == c_CTRL_END) begin
            w_fsm_next = c_ST_LOCKED;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (pending is still valid during FIRE; it clears on exit)
    // ------------------------------------------------------------------
    assign w_fire  = (r_fsm == c_ST_FIRE);
    assign up      = w_fire & r_pend[0];
    assign down    = w_fire & r_pend[1];
    assign left    = w_fire & r_pend[2];
    assign right   = w_fire & r_pend[3];
    assign switch  = w_fire & r_pend[4];
    assign busy    = (r_pend != 5'd0) || (r_fsm != c_ST_IDLE);
    assign dropped = |(w_rise & ~w_latch);

endmodule
`default_nettype wire

// File: tb/tb_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_ctrl
//  Description : Directed self-checking bench for key_ctrl with
//                DEBOUNCE_CYCLES = 4 (press-to-pulse latency of 8 cycles).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_ctrl;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_down, btn_left, btn_right, btn_switch;
    logic [2:0] state;
    logic       up, down, left, right, switch, busy, dropped;
    logic [4:0] w_pulses;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_up, cnt_down, cnt_left, cnt_right, cnt_switch, cnt_drop, cnt_busy;
    int total_multi = 0;

    assign w_pulses = {up, down, left, right, switch};

    key_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_switch (btn_switch),
        .state      (state),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .switch     (switch),
        .busy       (busy),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    // Advance one cycle; sample 1 time unit after the edge and tally activity.
    task automatic tick();
        @(posedge clk);
        #1;
        cnt_up     += int'(up);
        cnt_down   += int'(down);
        cnt_left   += int'(left);
        cnt_right  += int'(right);
        cnt_switch += int'(switch);
        cnt_drop   += int'(dropped);
        cnt_busy   += int'(busy);
        if ((int'(up) + int'(down) + int'(left) + int'(right) + int'(switch)) > 1)
            total_multi++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        cnt_up = 0; cnt_down = 0; cnt_left = 0; cnt_right = 0;
        cnt_switch = 0; cnt_drop = 0; cnt_busy = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_switch = 0;
        state = 3'b000;
        clear_counts();
        ticks(2);
        n_checks++; if (w_pulses !== 5'b00000) begin n_fail++; $display("FAIL reset_pulses: got %b want 00000", w_pulses); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL reset_dropped: got %b want 0", dropped); end
        rst = 1'b0;
        ticks(2);
        n_checks++; if ({w_pulses, busy, dropped} !== 7'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b want 0000000", {w_pulses, busy, dropped}); end
    endtask

    task automatic test_basic_press();
        clear_counts();
        btn_up = 1'b1;
        ticks(6);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_early: got %b want 0", busy); end
        tick();
        n_checks++; if ({w_pulses, busy} !== 6'b000001) begin n_fail++; $display("FAIL basic_latched: got %b want 000001", {w_pulses, busy}); end
        tick();
        n_checks++; if (w_pulses !== 5'b10000) begin n_fail++; $display("FAIL basic_up_pulse: got %b want 10000", w_pulses); end
        tick();
        n_checks++; if ({w_pulses, busy} !== 6'b000001) begin n_fail++; $display("FAIL basic_after_pulse: got %b want 000001", {w_pulses, busy}); end
        btn_up = 1'b0;
        ticks(3);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_wait_leave_busy: got %b want 1", busy); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_reject_idle: got %b want 0", busy); end
        ticks(8);
        n_checks++; if ({cnt_up, cnt_down, cnt_left, cnt_right, cnt_switch, cnt_drop} !== {32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0})
            begin n_fail++; $display("FAIL basic_counts: up=%0d down=%0d left=%0d right=%0d sw=%0d drop=%0d want 1,0,0,0,0,0", cnt_up, cnt_down, cnt_left, cnt_right, cnt_switch, cnt_drop); end
    endtask

    task automatic test_glitch();
        clear_counts();
        btn_left = 1'b1;
        ticks(DEB - 1);
        btn_left = 1'b0;
        ticks(12);
        n_checks++; if ({cnt_left, cnt_drop, cnt_busy} !== {32'd0, 32'd0, 32'd0})
            begin n_fail++; $display("FAIL glitch: left=%0d drop=%0d busy_cycles=%0d want 0,0,0", cnt_left, cnt_drop, cnt_busy); end
    endtask

    task automatic test_simultaneous();
        clear_counts();
        btn_down = 1'b1; btn_right = 1'b1;
        ticks(6);
        n_checks++; if ({dropped, busy} !== 2'b10) begin n_fail++; $display("FAIL simul_drop_cycle: dropped,busy got %b want 10", {dropped, busy}); end
        tick();
        n_checks++; if ({dropped, busy} !== 2'b01) begin n_fail++; $display("FAIL simul_latched: dropped,busy got %b want 01", {dropped, busy}); end
        tick();
        n_checks++; if (w_pulses !== 5'b01000) begin n_fail++; $display("FAIL simul_down_pulse: got %b want 01000", w_pulses); end
        btn_down = 1'b0; btn_right = 1'b0;
        ticks(12);
        n_checks++; if ({cnt_down, cnt_right, cnt_drop} !== {32'd1, 32'd0, 32'd1})
            begin n_fail++; $display("FAIL simul_counts: down=%0d right=%0d drop=%0d want 1,0,1", cnt_down, cnt_right, cnt_drop); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_handshake();
        clear_counts();
        btn_up = 1'b1;
        ticks(8);
        n_checks++; if (w_pulses !== 5'b10000) begin n_fail++; $display("FAIL hs_up_pulse: got %b want 10000", w_pulses); end
        state = 3'b001; btn_up = 1'b0;
        ticks(2);
        state = 3'b010; btn_left = 1'b1;
        ticks(6);
        n_checks++; if ({dropped, busy} !== 2'b11) begin n_fail++; $display("FAIL hs_drop_in_gen: dropped,busy got %b want 11", {dropped, busy}); end
        ticks(2);
        state = 3'b011; btn_left = 1'b0;
        ticks(2);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hs_busy_check: got %b want 1", busy); end
        state = 3'b000;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hs_return_idle: got %b want 0", busy); end
        n_checks++; if ({cnt_up, cnt_left, cnt_drop} !== {32'd1, 32'd0, 32'd1})
            begin n_fail++; $display("FAIL hs_counts: up=%0d left=%0d drop=%0d want 1,0,1", cnt_up, cnt_left, cnt_drop); end
        ticks(6);
        clear_counts();
        btn_left = 1'b1;
        ticks(7);
        n_checks++; if (w_pulses !== 5'b00000) begin n_fail++; $display("FAIL hs_left_early: got %b want 00000", w_pulses); end
        tick();
        n_checks++; if (w_pulses !== 5'b00100) begin n_fail++; $display("FAIL hs_left_pulse: got %b want 00100", w_pulses); end
        btn_left = 1'b0;
        ticks(12);
        n_checks++; if (cnt_left !== 1) begin n_fail++; $display("FAIL hs_left_count: got %0d want 1", cnt_left); end
    endtask

    task automatic test_not_input();
        clear_counts();
        state = 3'b101; btn_switch = 1'b1;
        ticks(7);
        n_checks++; if ({w_pulses, busy} !== 6'b000001) begin n_fail++; $display("FAIL ni_held: got %b want 000001", {w_pulses, busy}); end
        ticks(5);
        n_checks++; if ({w_pulses, busy} !== 6'b000001) begin n_fail++; $display("FAIL ni_still_held: got %b want 000001", {w_pulses, busy}); end
        state = 3'b000;
        tick();
        n_checks++; if (w_pulses !== 5'b00001) begin n_fail++; $display("FAIL ni_switch_pulse: got %b want 00001", w_pulses); end
        tick();
        n_checks++; if (w_pulses !== 5'b00000) begin n_fail++; $display("FAIL ni_single_cycle: got %b want 00000", w_pulses); end
        btn_switch = 1'b0;
        ticks(12);
        n_checks++; if ({cnt_switch, busy} !== {32'd1, 1'b0}) begin n_fail++; $display("FAIL ni_final: switch=%0d busy=%b want 1,0", cnt_switch, busy); end
    endtask

    task automatic test_end_lock();
        clear_counts();
        state = 3'b100;
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL end_busy: got %b want 1", busy); end
        btn_up = 1'b1;
        ticks(10);
        btn_up = 1'b0;
        ticks(8);
        btn_right = 1'b1;
        ticks(10);
        btn_right = 1'b0;
        state = 3'b000;
        ticks(8);
        n_checks++; if ((cnt_up + cnt_down + cnt_left + cnt_right + cnt_switch) !== 0)
            begin n_fail++; $display("FAIL end_no_pulses: got %0d pulses want 0", cnt_up + cnt_down + cnt_left + cnt_right + cnt_switch); end
        n_checks++; if (cnt_drop !== 2) begin n_fail++; $display("FAIL end_drops: got %0d want 2", cnt_drop); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL end_busy_held: got %b want 1", busy); end
    endtask

    task automatic test_async_reset();
        btn_down = 1'b1;
        ticks(3);
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({w_pulses, busy, dropped} !== 7'b0) begin n_fail++; $display("FAIL async_reset: got %b want 0000000", {w_pulses, busy, dropped}); end
        btn_down = 1'b0;
        ticks(2);
        rst = 1'b0;
        ticks(2);
        clear_counts();
        btn_down = 1'b1;
        ticks(7);
        n_checks++; if (w_pulses !== 5'b00000) begin n_fail++; $display("FAIL rr_early: got %b want 00000", w_pulses); end
        tick();
        n_checks++; if (w_pulses !== 5'b01000) begin n_fail++; $display("FAIL rr_down_pulse: got %b want 01000", w_pulses); end
        btn_down = 1'b0;
        ticks(12);
        n_checks++; if ({cnt_down, busy} !== {32'd1, 1'b0}) begin n_fail++; $display("FAIL rr_final: down=%0d busy=%b want 1,0", cnt_down, busy); end
    endtask

    initial begin
        test_reset();
        test_basic_press();
        test_glitch();
        test_simultaneous();
        test_handshake();
        test_not_input();
        test_end_lock();
        test_async_reset();
        n_checks++; if (total_multi !== 0) begin n_fail++; $display("FAIL exclusive_pulses: %0d multi-hot cycles want 0", total_multi); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
